// File: rtl/lb_resp_pkg.sv
// Shared constants and types for the local-bus register responder:
// register offsets, CTRL/STATUS bit positions, capture and read-select encodings.
package lb_resp_pkg;

  localparam logic [4:0] CFG_BASE   = 5'd0;
  localparam logic [4:0] OFF_STATUS = 5'd16;
  localparam logic [4:0] OFF_CTRL   = 5'd17;
  localparam logic [4:0] OFF_ID     = 5'd18;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_TRIG  = 2;

  // STATUS flag positions counted down from the MSB of the data word
  localparam int STATUS_DONE_OFS  = 0;
  localparam int STATUS_ARMED_OFS = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } cap_state_t;

  typedef enum logic [2:0] {
    SEL_ZERO   = 3'd0,
    SEL_CFG    = 3'd1,
    SEL_STATUS = 3'd2,
    SEL_ID     = 3'd3,
    SEL_BUF    = 3'd4
  } rd_sel_t;

endpackage

// File: rtl/lb_reg_responder_dpram.sv
// Simple dual-port RAM for the capture buffer: one write port, one registered
// read port, single clock. A same-address read and write returns the old word.
module lb_reg_responder_dpram #(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/lb_reg_responder.sv
// Local-bus target: address decode, config register bank, capture FSM feeding
// a buffer RAM, and a fixed-latency read pipeline returning data on lb_din.
module lb_reg_responder
  import lb_resp_pkg::*;
#(
  parameter int                    AW       = 24,
  parameter int                    DW       = 32,
  parameter int                    BUF_AW   = 13,
  parameter int                    NREG     = 16,
  parameter int                    READ_LAT = 3,
  parameter logic [AW-BUF_AW-2:0]  BASE     = '0,
  parameter logic [DW-1:0]         ID_WORD  = 32'h05C0_0001
) (
  input  logic               lb_clk,
  input  logic               reset,
  input  logic [AW-1:0]      lb_addr,
  input  logic               lb_strobe,
  input  logic               lb_rd,
  input  logic               lb_write,
  input  logic [DW-1:0]      lb_data,
  output logic [DW-1:0]      lb_din,
  output logic               rd_valid,
  output logic [NREG*DW-1:0] cfg,
  output logic               trig,
  input  logic [DW-1:0]      buf_data,
  input  logic               buf_valid,
  output logic               armed,
  output logic               done,
  output logic [1:0]         cap_state_dbg
);

  // Bus protocol: lb_strobe qualifies one access per cycle and there is no
  // backpressure. Every strobe with lb_rd produces exactly one rd_valid pulse
  // READ_LAT cycles later; lb_din is valid in that cycle and held until the next.

  localparam int         NDLY     = READ_LAT - 2;
  localparam logic [5:0] NREG_V   = 6'(NREG);
  localparam logic [BUF_AW-1:0] PTR_LAST = '1;

  logic       hit, in_buf, wr_en, rd_req, ctrl_wr;
  logic [4:0] off;

  assign hit     = (lb_addr[AW-1:BUF_AW+1] == BASE);
  assign in_buf  = lb_addr[BUF_AW];
  assign off     = lb_addr[4:0];
  assign wr_en   = lb_strobe & lb_write & ~lb_rd & hit & ~in_buf;
  assign rd_req  = lb_strobe & lb_rd;
  assign ctrl_wr = wr_en & (off == OFF_CTRL);

  // Register state
  logic [NREG-1:0][DW-1:0] cfg_q, cfg_d;
  logic                    trig_q, trig_d;
  cap_state_t              state_q, state_d;
  logic [BUF_AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic                    armed_q, armed_d;
  logic                    done_q, done_d;
  logic                    ram_we;

  // Read pipeline state
  logic              s1_valid_q, s1_valid_d;
  rd_sel_t           s1_sel_q, s1_sel_d;
  logic [3:0]        s1_idx_q, s1_idx_d;
  logic [BUF_AW-1:0] s1_baddr_q, s1_baddr_d;
  logic              s2_valid_q, s2_valid_d;
  rd_sel_t           s2_sel_q, s2_sel_d;
  logic [DW-1:0]     s2_reg_q, s2_reg_d;
  rd_sel_t           req_sel;
  logic [DW-1:0]     status_word, reg_rd_data, ram_rdata, s2_data;

  always_comb begin
    cfg_d = cfg_q;
    if (wr_en && ({1'b0, off} < NREG_V)) cfg_d[off[3:0]] = lb_data;
    trig_d = ctrl_wr & lb_data[CTRL_TRIG];
  end

  // Abort outranks arm; a sample arriving with an arm/abort write is dropped.
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    done_d   = done_q;
    ram_we   = 1'b0;
    if (ctrl_wr && lb_data[CTRL_ABORT]) begin
      state_d = IDLE;
    end else if (ctrl_wr && lb_data[CTRL_ARM]) begin
      state_d  = ARMED;
      wr_ptr_d = '0;
      done_d   = 1'b0;
    end else if (state_q == ARMED && buf_valid) begin
      ram_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + BUF_AW'(1);
      if (wr_ptr_q == PTR_LAST) begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end
    armed_d = (state_d == ARMED);
  end

  always_comb begin
    req_sel = SEL_ZERO;
    if (hit) begin
      if (in_buf)                        req_sel = SEL_BUF;
      else if ({1'b0, off} < NREG_V)     req_sel = SEL_CFG;
      else if (off == OFF_STATUS)        req_sel = SEL_STATUS;
      else if (off == OFF_ID)            req_sel = SEL_ID;
    end
  end

  always_comb begin
    s1_valid_d = rd_req;
    s1_sel_d   = rd_req ? req_sel : s1_sel_q;
    s1_idx_d   = rd_req ? off[3:0] : s1_idx_q;
    s1_baddr_d = rd_req ? lb_addr[BUF_AW-1:0] : s1_baddr_q;
  end

  always_comb begin
    status_word = '0;
    status_word[DW-1-STATUS_DONE_OFS]  = done_q;
    status_word[DW-1-STATUS_ARMED_OFS] = armed_q;
    status_word[BUF_AW-1:0]            = wr_ptr_q;
    reg_rd_data = '0;
    case (s1_sel_q)
      SEL_CFG:    reg_rd_data = cfg_q[s1_idx_q];
      SEL_STATUS: reg_rd_data = status_word;
      SEL_ID:     reg_rd_data = ID_WORD;
      default:    reg_rd_data = '0;
    endcase
  end

  // Stage 2 samples register values on the same edge the RAM output updates.
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_sel_d   = s1_valid_q ? s1_sel_q : s2_sel_q;
    s2_reg_d   = s1_valid_q ? reg_rd_data : s2_reg_q;
  end

  assign s2_data = (s2_sel_q == SEL_BUF) ? ram_rdata : s2_reg_q;

  always_ff @(posedge lb_clk) begin
    if (reset) begin
      cfg_q      <= '0;
      trig_q     <= 1'b0;
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      armed_q    <= 1'b0;
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_sel_q   <= SEL_ZERO;
      s1_idx_q   <= '0;
      s1_baddr_q <= '0;
      s2_valid_q <= 1'b0;
      s2_sel_q   <= SEL_ZERO;
      s2_reg_q   <= '0;
    end else begin
      cfg_q      <= cfg_d;
      trig_q     <= trig_d;
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
      s1_valid_q <= s1_valid_d;
      s1_sel_q   <= s1_sel_d;
      s1_idx_q   <= s1_idx_d;
      s1_baddr_q <= s1_baddr_d;
      s2_valid_q <= s2_valid_d;
      s2_sel_q   <= s2_sel_d;
      s2_reg_q   <= s2_reg_d;
    end
  end

  lb_reg_responder_dpram #(
    .AW (BUF_AW),
    .DW (DW)
  ) u_buf (
    .clk   (lb_clk),
    .we    (ram_we),
    .waddr (wr_ptr_q),
    .wdata (buf_data),
    .re    (s1_valid_q && (s1_sel_q == SEL_BUF)),
    .raddr (s1_baddr_q),
    .rdata (ram_rdata)
  );

  generate
    if (NDLY == 0) begin : g_no_dly
      assign lb_din   = s2_data;
      assign rd_valid = s2_valid_q;
    end else begin : g_dly
      logic [NDLY-1:0] dly_valid_q, dly_valid_d;
      logic [DW-1:0]   dly_data_q [NDLY];
      logic [DW-1:0]   dly_data_d [NDLY];

      // Each stage loads only with a valid word, so the output holds between reads.
      always_comb begin
        dly_valid_d[0] = s2_valid_q;
        dly_data_d[0]  = s2_valid_q ? s2_data : dly_data_q[0];
        for (int i = 1; i < NDLY; i++) begin
          dly_valid_d[i] = dly_valid_q[i-1];
          dly_data_d[i]  = dly_valid_q[i-1] ? dly_data_q[i-1] : dly_data_q[i];
        end
      end

      always_ff @(posedge lb_clk) begin
        if (reset) begin
          dly_valid_q <= '0;
          for (int i = 0; i < NDLY; i++) dly_data_q[i] <= '0;
        end else begin
          dly_valid_q <= dly_valid_d;
          for (int i = 0; i < NDLY; i++) dly_data_q[i] <= dly_data_d[i];
        end
      end

      assign lb_din   = dly_data_q[NDLY-1];
      assign rd_valid = dly_valid_q[NDLY-1];
    end
  endgenerate

  assign cfg           = cfg_q;
  assign trig          = trig_q;
  assign armed         = armed_q;
  assign done          = done_q;
  assign cap_state_dbg = state_q;

endmodule

// File: tb/tb_lb_reg_responder.sv
// Bench for lb_reg_responder: directed steps with randomized data and gaps,
// checked against a transaction-level model of the register map and buffer.
module tb_lb_reg_responder;

  localparam int AW       = 24;
  localparam int DW       = 32;
  localparam int BUF_AW   = 13;
  localparam int NREG     = 16;
  localparam int READ_LAT = 3;
  localparam int DEPTH    = 1 << BUF_AW;
  localparam logic [DW-1:0] ID_WORD = 32'h05C0_0001;

  logic               lb_clk = 1'b0;
  logic               reset = 1'b1;
  logic [AW-1:0]      lb_addr = '0;
  logic               lb_strobe = 1'b0;
  logic               lb_rd = 1'b0;
  logic               lb_write = 1'b0;
  logic [DW-1:0]      lb_data = '0;
  logic [DW-1:0]      lb_din;
  logic               rd_valid;
  logic [NREG*DW-1:0] cfg;
  logic               trig;
  logic [DW-1:0]      buf_data = '0;
  logic               buf_valid = 1'b0;
  logic               armed;
  logic               done;
  logic [1:0]         cap_state_dbg;

  lb_reg_responder dut (
    .lb_clk        (lb_clk),
    .reset         (reset),
    .lb_addr       (lb_addr),
    .lb_strobe     (lb_strobe),
    .lb_rd         (lb_rd),
    .lb_write      (lb_write),
    .lb_data       (lb_data),
    .lb_din        (lb_din),
    .rd_valid      (rd_valid),
    .cfg           (cfg),
    .trig          (trig),
    .buf_data      (buf_data),
    .buf_valid     (buf_valid),
    .armed         (armed),
    .done          (done),
    .cap_state_dbg (cap_state_dbg)
  );

  // clock / cycle counter
  always #5 lb_clk = ~lb_clk;
  int cyc = 0;
  always @(posedge lb_clk) cyc <= cyc + 1;

  // reference model
  logic [DW-1:0] cfg_m [NREG];
  logic [DW-1:0] ram_m [DEPTH];
  int            ptr_m;
  bit            armed_m, done_m, trig_m;

  // scoreboard
  logic [DW-1:0] exp_q [$];
  int            lat_q [$];
  int            n_vec = 0;
  int            n_err = 0;
  int            rv_seen = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] reg_a(input int o);
    return AW'(o);
  endfunction

  function automatic logic [AW-1:0] buf_a(input int w);
    return AW'(DEPTH + w);
  endfunction

  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] a);
    int o;
    if (a[AW-1:BUF_AW+1] != '0) return '0;
    if (a[BUF_AW]) return ram_m[a[BUF_AW-1:0]];
    o = int'(a[4:0]);
    if (o < NREG) return cfg_m[o];
    if (o == 16) return {done_m, armed_m, 17'b0, 13'(ptr_m)};
    if (o == 18) return ID_WORD;
    return '0;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NREG; k++) cfg_m[k] = '0;
    ptr_m = 0; armed_m = 0; done_m = 0; trig_m = 0;
  endtask

  // Apply this cycle's inputs to the model, then advance one clock.
  task automatic cycle();
    bit wr, ctl;
    int o;
    o   = int'(lb_addr[4:0]);
    wr  = lb_strobe && lb_write && !lb_rd && (lb_addr[AW-1:BUF_AW+1] == '0) && !lb_addr[BUF_AW];
    ctl = wr && (o == 17);
    trig_m = ctl && lb_data[2];
    if (wr && o < NREG) cfg_m[o] = lb_data;
    if (ctl && lb_data[1]) armed_m = 0;
    else if (ctl && lb_data[0]) begin
      armed_m = 1; ptr_m = 0; done_m = 0;
    end else if (armed_m && buf_valid) begin
      ram_m[ptr_m] = buf_data;
      if (ptr_m == DEPTH - 1) begin
        ptr_m = 0; armed_m = 0; done_m = 1;
      end else ptr_m++;
    end
    if (lb_strobe && lb_rd) begin
      exp_q.push_back(exp_read(lb_addr));
      lat_q.push_back(cyc);
    end
    @(posedge lb_clk);
    #1;
  endtask

  task automatic bus_idle();
    lb_strobe = 1'b0; lb_rd = 1'b0; lb_write = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    lb_addr = a; lb_data = d; lb_strobe = 1'b1; lb_write = 1'b1; lb_rd = 1'b0;
    cycle();
    bus_idle();
  endtask

  task automatic rd(input logic [AW-1:0] a);
    lb_addr = a; lb_strobe = 1'b1; lb_rd = 1'b1; lb_write = 1'b0;
    cycle();
    bus_idle();
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cycle();
    if (exp_q.size() != 0) begin
      check("read_timeout_pending", exp_q.size(), 0);
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic check_cfg(input string tag);
    for (int k = 0; k < NREG; k++)
      check($sformatf("%s_cfg%0d", tag, k), cfg[k*DW +: DW], cfg_m[k]);
  endtask

  // read-return monitor
  always @(negedge lb_clk) begin
    if (rd_valid === 1'b1) begin
      rv_seen++;
      if (exp_q.size() == 0) begin
        check("spurious_rd_valid", {31'b0, rd_valid}, '0);
      end else begin
        check("rd_data", lb_din, exp_q.pop_front());
        check("rd_latency", cyc - lat_q.pop_front(), READ_LAT);
      end
    end
  end

  initial begin
    int idx, n, rv_before;
    bit v;
    logic [AW-1:0] a;

    model_reset();
    repeat (3) @(posedge lb_clk);
    #1;
    reset = 1'b0;

    // reset state
    check("rst_lb_din", lb_din, '0);
    check("rst_rd_valid", {31'b0, rd_valid}, '0);
    check("rst_trig", {31'b0, trig}, '0);
    check("rst_armed", {31'b0, armed}, '0);
    check("rst_done", {31'b0, done}, '0);
    check_cfg("rst");

    // ID read and latency
    rd(reg_a(18));
    drain();

    // cfg write/readback, RO writes ignored
    wr(reg_a(5), 32'hA5A5_0003);
    check_cfg("cfg5");
    rd(reg_a(5));
    drain();
    for (int i = 0; i < 6; i++) wr(reg_a($urandom_range(0, NREG-1)), $urandom);
    wr(reg_a(16), $urandom);
    wr(reg_a(18), $urandom);
    check_cfg("cfgrand");
    for (int k = 0; k < NREG; k++) begin
      lb_addr = reg_a(k); lb_strobe = 1'b1; lb_rd = 1'b1;
      cycle();
    end
    bus_idle();
    rd(reg_a(18));
    drain();

    // full capture with random gaps
    wr(reg_a(17), 32'h1);
    check("arm_armed", {31'b0, armed}, {31'b0, armed_m});
    idx = 0;
    while (idx < DEPTH) begin
      v = ($urandom_range(0, 3) != 0);
      buf_valid = v; buf_data = idx;
      cycle();
      if (v) idx++;
    end
    buf_valid = 1'b0;
    check("full_done", {31'b0, done}, {31'b0, done_m});
    check("full_armed", {31'b0, armed}, {31'b0, armed_m});
    rd(buf_a(0)); rd(buf_a(4095)); rd(buf_a(8191));
    for (int i = 0; i < 5; i++) rd(buf_a($urandom_range(0, DEPTH-1)));
    drain();
    buf_valid = 1'b1; buf_data = 32'hDEAD_BEEF;
    cycle();
    buf_valid = 1'b0;
    rd(buf_a(0));
    rd(reg_a(16));
    drain();

    // arm coinciding with a sample, then abort
    lb_addr = reg_a(17); lb_data = 32'h1; lb_strobe = 1'b1; lb_write = 1'b1;
    buf_valid = 1'b1; buf_data = 32'd7;
    cycle();
    bus_idle();
    buf_data = 32'd9;
    cycle();
    n = $urandom_range(3, 20);
    for (int i = 0; i < n; i++) begin
      buf_data = $urandom;
      cycle();
    end
    buf_valid = 1'b0;
    rd(buf_a(0)); rd(buf_a(1)); rd(reg_a(16));
    drain();
    wr(reg_a(17), 32'h3);
    check("abort_armed", {31'b0, armed}, {31'b0, armed_m});
    buf_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      buf_data = $urandom;
      cycle();
    end
    buf_valid = 1'b0;
    rd(reg_a(16)); rd(buf_a(ptr_m));
    drain();

    // back-to-back reads
    lb_strobe = 1'b1; lb_rd = 1'b1;
    lb_addr = reg_a(18); cycle();
    lb_addr = reg_a(0);  cycle();
    lb_addr = reg_a(16); cycle();
    lb_addr = reg_a(31); cycle();
    bus_idle();
    drain();

    // BASE mismatch accesses
    wr(AW'(24'h00_4000), $urandom);
    wr(AW'(24'h80_0005), $urandom);
    rd(AW'(24'h00_4012));
    rd(AW'(24'h10_2000));
    drain();
    check_cfg("basemiss");

    // random mixed traffic
    for (int i = 0; i < 80; i++) begin
      a = AW'($urandom);
      if ($urandom_range(0, 3) != 0) a[AW-1:BUF_AW+1] = '0;
      if (!a[BUF_AW] && a[4:0] == 5'd17) a[4:0] = 5'd18;
      case ($urandom_range(0, 3))
        0:       begin lb_write = 1'b1; lb_rd = 1'b0; end
        1:       begin lb_write = 1'b1; lb_rd = 1'b1; end
        default: begin lb_write = 1'b0; lb_rd = 1'b1; end
      endcase
      lb_addr = a; lb_data = $urandom; lb_strobe = 1'b1;
      cycle();
      bus_idle();
      if ($urandom_range(0, 1) != 0) cycle();
    end
    drain();
    check_cfg("rand");

    // reset one cycle after a read strobe
    rv_before = rv_seen;
    lb_addr = reg_a(18); lb_strobe = 1'b1; lb_rd = 1'b1;
    @(posedge lb_clk);
    #1;
    bus_idle();
    reset = 1'b1;
    @(posedge lb_clk);
    #1;
    @(posedge lb_clk);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) cycle();
    check("flush_rd_valid_count", rv_seen, rv_before);
    check("flush_lb_din", lb_din, '0);
    check("flush_armed", {31'b0, armed}, '0);
    check("flush_done", {31'b0, done}, '0);
    check_cfg("flush");
    rd(reg_a(16));
    drain();

    // trig pulse
    wr(reg_a(17), 32'h4);
    check("trig_pulse", {31'b0, trig}, {31'b0, trig_m});
    check("trig_armed", {31'b0, armed}, {31'b0, armed_m});
    cycle();
    check("trig_clear", {31'b0, trig}, {31'b0, trig_m});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
